// File: rtl/dmem_access_unit.sv
// dmem_access_unit: turns CPU loads/stores into aligned byte-enabled memory request/ack transactions
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_laddr,
  input  logic [1:0]        cpu_ssize,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q, cpu_rdata_q;
  logic [2:0]        ltype_q;
  logic [1:0]        off_q;
  logic [2:0]        ltype;
  logic [1:0]        ssize, off;
  logic              is_st, is_ld, idle, mis, go, ack;
  logic [3:0]        be;
  logic [31:0]       wdata, ld_data;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  // Decode the CPU request: aliases fold to word size, a store overrides a simultaneous load
  always_comb begin
    off          = cpu_addr[1:0];
    ltype        = cpu_laddr > 3'd4 ? 3'd0 : cpu_laddr;
    ssize        = cpu_ssize == 2'd3 ? 2'd0 : cpu_ssize;
    is_st        = cpu_we;
    is_ld        = cpu_re & ~cpu_we;
    mis          = is_st ? (ssize == 2'd0 ? |off : ssize == 2'd2 ? off[0] : 1'b0)
                 : is_ld ? (ltype == 3'd0 ? |off : ltype >= 3'd3 ? off[0] : 1'b0) : 1'b0;
    idle         = state_q == IDLE && !rst;
    cpu_misalign = idle & mis;
    go           = idle & (is_st | is_ld) & ~mis;
    ack          = state_q == REQ && mem_ack;
    cpu_stall    = go | (state_q == REQ && !rst);
    be           = (!is_st || ssize == 2'd0) ? 4'hF : ssize == 2'd1 ? 4'b0001 << off : off[1] ? 4'hC : 4'h3;
    wdata        = ssize == 2'd1 ? {4{cpu_wdata[7:0]}} : ssize == 2'd2 ? {2{cpu_wdata[15:0]}} : cpu_wdata;
    sel_b        = mem_rdata[{off_q, 3'b000} +: 8];
    sel_h        = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data      = ltype_q == 3'd1 ? {{24{sel_b[7]}}, sel_b}
                 : ltype_q == 3'd2 ? {24'b0, sel_b}
                 : ltype_q == 3'd3 ? {{16{sel_h[15]}}, sel_h}
                 : ltype_q == 3'd4 ? {16'b0, sel_h} : mem_rdata;
    state_d      = state_q == IDLE ? (go ? REQ : IDLE) : state_q == REQ ? (mem_ack ? DONE : REQ) : IDLE;
  end
  // Launch the memory request from IDLE, hold it stable until ack, then capture load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ltype_q     <= '0;
      off_q       <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= is_st;
        mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_be_q    <= be;
        mem_wdata_q <= wdata;
        ltype_q     <= ltype;
        off_q       <= off;
      end else if (ack) begin
        mem_req_q <= 1'b0;
        if (!mem_we_q) cpu_rdata_q <= ld_data;
      end
    end
  end
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: transaction-level model check of dmem_access_unit with directed and random traffic
module tb_dmem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_laddr = '0;
  logic [1:0]  cpu_ssize = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_misalign, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        chk_en = 1'b0, exp_stall = 1'b0, exp_mis = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_zero = 1'b1;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0, model_rdata = '0;
  logic [3:0]  exp_be = '0;
  int          pass_cnt = 0, tot_cnt = 0, stall_total = 0;
  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_laddr(cpu_laddr),
    .cpu_ssize(cpu_ssize), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", n, a, e);
  endtask
  function automatic int access_bytes(input logic st, input logic [1:0] ss, input logic [2:0] lt);
    if (st) return ss == 2'd1 ? 1 : ss == 2'd2 ? 2 : 4;
    return (lt == 3'd1 || lt == 3'd2) ? 1 : (lt == 3'd3 || lt == 3'd4) ? 2 : 4;
  endfunction
  function automatic logic ref_mis(input logic st, input logic [1:0] ss, input logic [2:0] lt, input logic [31:0] a);
    return (a % access_bytes(st, ss, lt)) != 0;
  endfunction
  function automatic logic [3:0] ref_be(input logic st, input logic [1:0] ss, input logic [1:0] k);
    int n;
    n = access_bytes(st, ss, 3'd0);
    return st ? 4'(((1 << n) - 1) << k) : 4'hF;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [1:0] ss, input logic [31:0] d);
    return ss == 2'd1 ? (d & 32'hFF) * 32'h0101_0101 : ss == 2'd2 ? (d & 32'hFFFF) * 32'h0001_0001 : d;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] lt, input logic [1:0] k);
    logic [31:0] b, h;
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (16 * k[1])) & 32'hFFFF;
    if (lt == 3'd1) return b >= 128 ? b - 256 : b;
    if (lt == 3'd2) return b;
    if (lt == 3'd3) return h >= 32768 ? h - 65536 : h;
    if (lt == 3'd4) return h;
    return w;
  endfunction
  always @(negedge clk) begin
    if (cpu_stall === 1'b1) stall_total++;
    if (chk_en) begin
      chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
      chk("cpu_misalign", 32'(cpu_misalign), 32'(exp_mis));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      if (exp_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_zero) begin
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic re, input logic we, input logic [2:0] lt, input logic [1:0] ss,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic act, m;
    act = re | we;
    m = act && ref_mis(we, ss, lt, a);
    step();
    rst = 1'b0; cpu_re = re; cpu_we = we; cpu_laddr = lt; cpu_ssize = ss; cpu_addr = a; cpu_wdata = wd;
    mem_ack = 1'b0; exp_zero = 1'b0; exp_mis = m; exp_stall = act && !m; exp_req = 1'b0; exp_rdata = model_rdata;
    if (act && !m) begin
      for (int i = 0; i <= waits; i++) begin
        step();
        exp_mis = 1'b0; exp_stall = 1'b1; exp_req = 1'b1; exp_we = we;
        exp_addr = a & 32'hFFFF_FFFC; exp_be = ref_be(we, ss, a[1:0]); exp_wdata = ref_wdata(ss, wd);
        mem_ack = i == waits;
        mem_rdata = i == waits ? rd : $urandom;
      end
      step();
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      exp_stall = 1'b0; exp_req = 1'b0;
      if (!we) model_rdata = ref_load(rd, lt, a[1:0]);
      exp_rdata = model_rdata;
    end
    step();
    cpu_re = 1'b0; cpu_we = 1'b0; mem_ack = 1'($urandom_range(0, 1));
    exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0;
  endtask
  initial begin
    int s0;
    rst = 1'b1; cpu_re = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    step();
    chk("model_lb", ref_load(32'h80FF_1234, 3'd1, 2'd3), 32'hFFFF_FF80);
    chk("model_lhu", ref_load(32'h9ABC_0000, 3'd4, 2'd2), 32'h0000_9ABC);
    chk("model_sb_be", 32'(ref_be(1'b1, 2'd1, 2'd1)), 32'h2);
    chk("model_sh_wdata", ref_wdata(2'd2, 32'h1234_56AB), 32'h56AB_56AB);
    s0 = stall_total;
    txn(1, 0, 3'd1, 2'd0, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lb_result", cpu_rdata, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(stall_total - s0), 32'd2);
    txn(1, 0, 3'd2, 2'd0, 32'h1003, 0, 32'h80FF_1234, 0);
    chk("lbu_result", cpu_rdata, 32'h0000_0080);
    s0 = stall_total;
    txn(1, 0, 3'd3, 2'd0, 32'h2002, 0, 32'h9ABC_0000, 3);
    chk("lh_result", cpu_rdata, 32'hFFFF_9ABC);
    chk("lh_stall_cycles", 32'(stall_total - s0), 32'd5);
    txn(1, 0, 3'd4, 2'd0, 32'h2002, 0, 32'h9ABC_0000, 3);
    chk("lhu_result", cpu_rdata, 32'h0000_9ABC);
    txn(0, 1, 3'd0, 2'd1, 32'h3001, 32'h1234_56AB, 0, 1);
    txn(0, 1, 3'd0, 2'd2, 32'h3002, 32'h1234_56AB, 0, 0);
    chk("store_keeps_rdata", cpu_rdata, 32'h0000_9ABC);
    txn(1, 0, 3'd0, 2'd0, 32'h4002, 0, 0, 0);
    txn(0, 1, 3'd0, 2'd2, 32'h4001, 32'h5555_5555, 0, 0);
    chk("misalign_keeps_rdata", cpu_rdata, 32'h0000_9ABC);
    step();
    cpu_re = 1'b1; cpu_laddr = 3'd3; cpu_addr = 32'h2002; mem_ack = 1'b0;
    exp_stall = 1'b1; exp_mis = 1'b0; exp_req = 1'b0;
    step();
    rst = 1'b1; exp_stall = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h2000; exp_be = 4'hF;
    step();
    rst = 1'b0; cpu_re = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    exp_req = 1'b0; exp_zero = 1'b1; model_rdata = '0; exp_rdata = '0;
    step();
    step();
    mem_ack = 1'b0;
    for (int n = 0; n < 300; n++)
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
